// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller
//   Time-multiplexed scan controller that feeds a 7-segment decoder/selector.
//   It holds an 8-digit hex word and a per-digit enable mask, and steps
//   o_select through the digits at one digit slot every TICK_DIV clocks.
//   For the digit being scanned it presents the nibble on o_digit and a
//   blank flag on o_blank.
//   Loads are double-buffered. A word captured on i_load waits in a pending
//   buffer and is copied into the active registers only on the edge where
//   o_select wraps back to 0, so a frame is never shown half old, half new.
//
//   Optional feature macro: SEG7_SCAN_LZB_EN
//     When defined, leading-zero blanking also darkens digit i>0 if its nibble
//     and every enabled higher digit are zero. Digit 0 is never blanked by this
//     rule. When undefined, no blanking logic beyond the enable mask is built.

module seg7_scan_controller #(
    parameter int unsigned TICK_DIV   = 100000,  // clocks per digit slot, >= 1
    parameter int unsigned NUM_DIGITS = 8        // digits scanned, 1..8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_data_in,     // nibble i drives digit i
    input  logic [7:0]  i_en_in,       // bit i enables digit i
    input  logic        i_load,        // 1-cycle strobe: capture data/enable
    output logic [3:0]  o_digit,       // nibble of the active word at o_select
    output logic [2:0]  o_select,      // digit index currently driven
    output logic        o_blank,       // 1 = current digit is dark
    output logic        o_pending,     // 1 = a loaded word awaits the frame boundary
    output logic        o_frame_done   // 1-cycle pulse after o_select wraps to 0
);

    // Prescaler width; a divide-by-1 still needs a 1-bit register to exist.
    localparam int unsigned    PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [2:0]     SEL_LAST  = 3'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] r_presc;       // 0..TICK_DIV-1 slot timer
    logic [2:0]    r_select;      // digit index being scanned
    logic          r_frame_done;  // registered wrap pulse

    logic [31:0]   r_act_data;    // word currently displayed
    logic [7:0]    r_act_mask;    // enable mask currently displayed
    logic [31:0]   r_pend_data;   // word waiting for the frame boundary
    logic [7:0]    r_pend_mask;   // mask waiting for the frame boundary
    logic          r_pending;     // pending buffer holds an unshown word

    // ------------------------------------------------------------------
    // Slot timing
    // ------------------------------------------------------------------
    logic w_tick;  // last clock of the current digit slot
    logic w_wrap;  // last clock of the last digit slot: frame boundary

    assign w_tick = (r_presc == TICK_LAST);
    assign w_wrap = w_tick && (r_select == SEL_LAST);

    // Prescaler: count clocks within a digit slot and wrap at TICK_DIV-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Scan position: advance one digit per slot and flag the frame wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_select     <= 3'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_tick) begin
                r_select <= (r_select == SEL_LAST) ? 3'd0 : r_select + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Double buffer
    // ------------------------------------------------------------------
    // Pending buffer: capture every load that does not coincide with the
    // frame boundary; a later load in the same frame simply overwrites it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: these buffers are a handful of flops, not a RAM, so they
            // are cleared on reset; a lost pending load is intended.
            r_pend_data <= '0;
            r_pend_mask <= '0;
            r_pending   <= 1'b0;
        end else if (w_wrap) begin
            // The boundary consumes either the pending word or a colliding
            // load, so nothing is left waiting afterwards.
            r_pending <= 1'b0;
        end else if (i_load) begin
            r_pend_data <= i_data_in;
            r_pend_mask <= i_en_in;
            r_pending   <= 1'b1;
        end
    end

    // Active registers: change only at the frame boundary. A load arriving on
    // that very edge is newer than anything pending and goes straight through.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act_data <= '0;
            r_act_mask <= '0;
        end else if (w_wrap) begin
            if (i_load) begin
                r_act_data <= i_data_in;
                r_act_mask <= i_en_in;
            end else if (r_pending) begin
                r_act_data <= r_pend_data;
                r_act_mask <= r_pend_mask;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output path (combinational from o_select and the active registers)
    // ------------------------------------------------------------------
    logic w_mask_blank;

    assign w_mask_blank = ~r_act_mask[r_select];

`ifdef SEG7_SCAN_LZB_EN
    logic [7:0] w_lz_blank;  // per-digit leading-zero blank

    // Leading-zero detect: walk from the top digit down, remembering whether
    // every enabled digit seen so far is zero; disabled digits do not count.
    always_comb begin
        logic w_hi_zero;
        logic w_nib_zero;
        // NOTE: every variable gets a default before any conditional
        // assignment, otherwise the tool infers a latch to hold its old value.
        w_lz_blank = '0;
        w_hi_zero  = 1'b1;
        w_nib_zero = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (i < int'(NUM_DIGITS)) begin
                w_nib_zero = (r_act_data[4*i +: 4] == 4'h0);
                if (i > 0) begin
                    w_lz_blank[i] = w_hi_zero && w_nib_zero;
                end
                w_hi_zero = w_hi_zero && (!r_act_mask[i] || w_nib_zero);
            end
        end
    end

    assign o_blank = w_mask_blank | w_lz_blank[r_select];
`else
    assign o_blank = w_mask_blank;
`endif

    assign o_digit      = r_act_data[{r_select, 2'b00} +: 4];
    assign o_select     = r_select;
    assign o_pending    = r_pending;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller
//   Self-checking bench for seg7_scan_controller with TICK_DIV=4, NUM_DIGITS=8,
//   plus a second instance with TICK_DIV=1. Expected frame contents are pushed
//   to a scoreboard queue when a word is loaded and popped slot by slot while
//   the design scans. Honours SEG7_SCAN_LZB_EN in its expected blank flags.

`timescale 1ns/1ps

module tb_seg7_scan_controller;

    localparam int TICK_DIV   = 4;
    localparam int NUM_DIGITS = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] i_data_in;
    logic [7:0]  i_en_in;
    logic        i_load;
    logic [3:0]  o_digit;
    logic [2:0]  o_select;
    logic        o_blank;
    logic        o_pending;
    logic        o_frame_done;

    // Fast instance (divide-by-1), never loaded.
    logic [31:0] f_data_in;
    logic [7:0]  f_en_in;
    logic        f_load;
    logic [3:0]  f_digit;
    logic [2:0]  f_select;
    logic        f_blank;
    logic        f_pending;
    logic        f_frame_done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] sel;
        logic [3:0] digit;
        logic       blank;
    } exp_t;

    exp_t sb_q[$];

    seg7_scan_controller #(.TICK_DIV(TICK_DIV), .NUM_DIGITS(NUM_DIGITS)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data_in    (i_data_in),
        .i_en_in      (i_en_in),
        .i_load       (i_load),
        .o_digit      (o_digit),
        .o_select     (o_select),
        .o_blank      (o_blank),
        .o_pending    (o_pending),
        .o_frame_done (o_frame_done)
    );

    seg7_scan_controller #(.TICK_DIV(1), .NUM_DIGITS(NUM_DIGITS)) dut_fast (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data_in    (f_data_in),
        .i_en_in      (f_en_in),
        .i_load       (f_load),
        .o_digit      (f_digit),
        .o_select     (f_select),
        .o_blank      (f_blank),
        .o_pending    (f_pending),
        .o_frame_done (f_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected blank flag for digit i of a word/mask, straight from the
    // behavioural description of masking and leading-zero blanking.
    function automatic logic exp_blank(input logic [31:0] d, input logic [7:0] m, input int i);
        logic b;
        logic all_zero;
        b        = !m[i];
        all_zero = 1'b0;
`ifdef SEG7_SCAN_LZB_EN
        if (i > 0 && d[4*i +: 4] == 4'h0) begin
            all_zero = 1'b1;
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                if (m[j] && d[4*j +: 4] != 4'h0) all_zero = 1'b0;
            end
        end
`endif
        return b | all_zero;
    endfunction

    task automatic push_frame(input logic [31:0] d, input logic [7:0] m);
        exp_t e;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            e.sel   = 3'(i);
            e.digit = d[4*i +: 4];
            e.blank = exp_blank(d, m, i);
            sb_q.push_back(e);
        end
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_sel"},   32'(o_select), 32'(e.sel));
            check({tag, "_digit"}, 32'(o_digit),  32'(e.digit));
            check({tag, "_blank"}, 32'(o_blank),  32'(e.blank));
        end
    endtask

    // All waits below start and end #1 after a rising edge.
    task automatic wait_sel(input logic [2:0] s);
        bit found;
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(posedge clk); #1;
            if (o_select == s) found = 1;
        end
        if (!found) check("wait_sel_timeout", 32'(o_select), 32'(s));
    endtask

    task automatic wait_frame();
        bit found;
        found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(posedge clk); #1;
            if (o_frame_done) found = 1;
        end
        if (!found) check("wait_frame_timeout", 32'(o_frame_done), 32'd1);
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] m);
        i_data_in = d;
        i_en_in   = m;
        i_load    = 1'b1;
        @(posedge clk); #1;
        i_load    = 1'b0;
    endtask

    // Compare one frame, one sample per digit slot starting at select 0.
    task automatic scan_frame(input string tag, input bit need_wait);
        if (need_wait) wait_frame();
        for (int i = 0; i < NUM_DIGITS; i++) begin
            pop_compare(tag);
            if (i < NUM_DIGITS - 1) begin
                repeat (TICK_DIV) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        exp_t e;
        int   fd_count;

        rst_n     = 1'b0;
        i_data_in = '0;
        i_en_in   = '0;
        i_load    = 1'b0;
        f_data_in = '0;
        f_en_in   = '0;
        f_load    = 1'b0;

        // ---- 1: reset values, load ignored in reset, scan cadence ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_select",     32'(o_select),     32'd0);
        check("rst_digit",      32'(o_digit),      32'd0);
        check("rst_blank",      32'(o_blank),      32'd1);
        check("rst_pending",    32'(o_pending),    32'd0);
        check("rst_frame_done", 32'(o_frame_done), 32'd0);
        do_load(32'hDEAD_BEEF, 8'hFF);
        check("rst_load_ignored", 32'(o_pending), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            e.sel   = 3'((k / TICK_DIV) % NUM_DIGITS);
            e.digit = 4'h0;
            e.blank = 1'b1;
            sb_q.push_back(e);
        end
        fd_count = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            pop_compare("cadence");
            check("cadence_fd", 32'(o_frame_done),
                  32'((k % (TICK_DIV * NUM_DIGITS)) == 0));
            if (o_frame_done) fd_count++;
            check("fast_sel", 32'(f_select), 32'(k % NUM_DIGITS));
            check("fast_fd",  32'(f_frame_done), 32'((k % NUM_DIGITS) == 0));
        end
        check("frame_done_count", 32'(fd_count), 32'd1);

        // ---- 2: load at select 3, swap at the wrap ----
        wait_sel(3'd3);
        do_load(32'h1234_5678, 8'hFF);
        check("load_pending", 32'(o_pending), 32'd1);
        push_frame(32'h1234_5678, 8'hFF);
        wait_frame();
        check("swap_pending_clear", 32'(o_pending), 32'd0);
        scan_frame("swap", 0);

        // ---- 3a: two loads in one frame, last one wins ----
        wait_frame();
        wait_sel(3'd1);
        do_load(32'hAAAA_AAAA, 8'hFF);
        wait_sel(3'd2);
        do_load(32'h0000_00C5, 8'hFF);
        check("overwrite_pending", 32'(o_pending), 32'd1);
        push_frame(32'h0000_00C5, 8'hFF);
        scan_frame("overwrite", 1);

        // ---- 3b: load on the wrapping edge bypasses a stale pending word ----
        wait_frame();
        do_load(32'h0000_0077, 8'hFF);
        check("stale_pending", 32'(o_pending), 32'd1);
        repeat (TICK_DIV * NUM_DIGITS - 2) @(posedge clk);
        #1;
        do_load(32'h0000_0009, 8'hFF);
        check("collide_pending", 32'(o_pending),    32'd0);
        check("collide_fd",      32'(o_frame_done), 32'd1);
        push_frame(32'h0000_0009, 8'hFF);
        scan_frame("collide", 0);

        // ---- 4: enable mask ----
        do_load(32'h1234_5678, 8'b0000_0101);
        push_frame(32'h1234_5678, 8'b0000_0101);
        scan_frame("mask", 1);

        // ---- 5: async reset mid-frame with a pending word ----
        wait_sel(3'd5);
        do_load(32'hFFFF_FFFF, 8'hFF);
        check("pre_rst_pending", 32'(o_pending), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_select",     32'(o_select),     32'd0);
        check("arst_digit",      32'(o_digit),      32'd0);
        check("arst_blank",      32'(o_blank),      32'd1);
        check("arst_pending",    32'(o_pending),    32'd0);
        check("arst_frame_done", 32'(o_frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(32'h0, 8'h00);
        scan_frame("post_rst", 1);
        check("post_rst_pending", 32'(o_pending), 32'd0);

        // ---- 6: leading-zero patterns (masking only when LZB is off) ----
        do_load(32'h0000_0450, 8'hFF);
        push_frame(32'h0000_0450, 8'hFF);
        scan_frame("lzb_450", 1);

        do_load(32'h0000_0000, 8'hFF);
        push_frame(32'h0000_0000, 8'hFF);
        scan_frame("lzb_zero", 1);

        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
